uart_rx_poller: RTL and testbench

Bus initiator for the UART register interface on the core data bus: polls the status register, reads the data register when a received byte is present, and delivers each byte on a valid/ready stream. Sits between a UART register device and a byte consumer (loader, console monitor) wherever no CPU is present to drive the UART. Read-only master; it never writes UART registers.

---
 rtl/uart_rx_poller_pkg.sv | 40 ++++
 rtl/uart_rx_poller_if.sv | 38 +++
 rtl/uart_rx_poller_bus_rd_engine.sv | 82 ++++++++
 rtl/uart_rx_poller.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_poller.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_poller_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_poll_pkg
// Description : Shared types and constants for the UART receive poller.
//               Holds the poller state encoding, the UART register offsets,
//               the byte-lane enable used for byte reads and a helper that
//               forms a register address from the device base.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_poll_pkg;

  // Poller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STAT_REQ  = 3'd1,
    ST_STAT_WAIT = 3'd2,
    ST_DATA_REQ  = 3'd3,
    ST_DATA_WAIT = 3'd4,
    ST_HOLD      = 3'd5,
    ST_GAP       = 3'd6
  } poll_state_t;

  // UART register map offsets from the device base.
  localparam logic [3:0] UART_DATA_OFS = 4'h0;
  localparam logic [3:0] UART_STAT_OFS = 4'h8;

  // Status bit that flags a received byte waiting in the data register.
  localparam int STAT_RXV_BIT = 0;

  // Only byte lane 0 is read; the UART registers carry 8 useful bits.
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Register address = device base plus register offset.
  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input logic [3:0]  ofs);
    return base + {28'h0, ofs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_poller_if.sv
`default_nettype none
// ============================================================================
// Interface   : uart_rx_poller_if
// Description : Core data-bus read/write channel between a bus initiator and
//               a register device.
//   addr   [31:0]  byte address of the access
//   req            request, held until gnt
//   we             write enable (reads only from the poller)
//   be     [3:0]   byte-lane enables
//   wdata  [31:0]  write data
//   gnt            request accepted this cycle
//   rvalid         read response valid
//   rdata  [31:0]  read data, valid with rvalid
//   err            bus error, valid with rvalid
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_poller_if;
  logic [31:0] addr;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output addr, req, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  addr, req, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_poller_bus_rd_engine.sv
`default_nettype none
// ============================================================================
// Module      : bus_rd_engine
// Description : Issues one bus read at a time. A start request while idle
//               raises req (with address and byte enables) on the next edge;
//               req is held until gnt. The response is then awaited with a
//               wait counter that aborts the read after TIMEOUT cycles.
// Ports       :
//   clk, resetn      clock, synchronous active-low reset
//   start            read wanted (accepted only while idle)
//   rd_addr [31:0]   address for the read being started
//   bus              bus master side
//   issued           request accepted by the bus this cycle
//   done             read finished this cycle (response or timeout)
//   rd_data [31:0]   read data, meaningful with done
//   rd_err           bus error or timeout, meaningful with done
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rd_engine
  import uart_poll_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [31:0]            rd_addr,
  uart_rx_poller_if.master       bus,
  output logic                   issued,
  output logic                   done,
  output logic [31:0]            rd_data,
  output logic                   rd_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic       waiting;
  logic [7:0] wait_cnt;
  logic       timeout;

  // A response landing on the last permitted wait cycle still counts.
  assign timeout = waiting & ~bus.rvalid & (wait_cnt == TO_LAST);
  assign issued  = bus.req & bus.gnt;
  assign done    = waiting & (bus.rvalid | timeout);
  assign rd_data = bus.rdata;
  assign rd_err  = ~bus.rvalid | bus.err;

  // Read-only initiator.
  assign bus.we    = 1'b0;
  assign bus.wdata = 32'h0;

  // rvalid is only looked at while waiting, so a response in the gnt cycle
  // or one arriving after a timeout abort is ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.req  <= 1'b0;
      bus.be   <= 4'b0000;
      bus.addr <= 32'h0;
      waiting  <= 1'b0;
      wait_cnt <= 8'h00;
    end else if (bus.req) begin
      if (bus.gnt) begin
        bus.req  <= 1'b0;
        bus.be   <= 4'b0000;
        waiting  <= 1'b1;
        wait_cnt <= 8'h00;
      end
    end else if (waiting) begin
      if (done) begin
        waiting <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else if (start) begin
      bus.req  <= 1'b1;
      bus.be   <= BE_BYTE0;
      bus.addr <= rd_addr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_poller.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_poller
// Description : Read-only bus initiator that polls a UART status register,
//               fetches the data register when a byte is present and hands
//               each byte to a consumer over a valid/ready stream.
// Ports       :
//   clk, resetn        clock, synchronous active-low reset
//   enable             polling enabled (acted on at IDLE/GAP/HOLD exits)
//   bus                core data bus, master side
//   byte_data [7:0]    received byte
//   byte_valid         byte_data valid
//   byte_ready         consumer accepts byte
//   busy               sequencer not idle
//   err_flag           sticky bus-error/timeout flag
//   clr_err            clears err_flag (a same-cycle error wins)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_poller
  import uart_poll_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  uart_rx_poller_if.master  bus,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              err_flag,
  input  logic              clr_err
);

  localparam logic [31:0] STAT_ADDR = reg_addr(BASE_ADDR, UART_STAT_OFS);
  localparam logic [31:0] DATA_ADDR = reg_addr(BASE_ADDR, UART_DATA_OFS);
  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP - 1);

  poll_state_t state;
  logic [7:0]  gap_cnt;

  logic        start;
  logic [31:0] rd_addr;
  logic        issued;
  logic        done;
  logic [31:0] rd_data;
  logic        rd_err;

  // The engine raises req on the edge after a *_REQ state is entered.
  assign start   = (state == ST_STAT_REQ) || (state == ST_DATA_REQ);
  assign rd_addr = (state == ST_DATA_REQ) ? DATA_ADDR : STAT_ADDR;

  // Only the low byte of data and the RX-valid status bit matter.
  logic unused_rd_data_hi;
  assign unused_rd_data_hi = ^rd_data[31:8];

  bus_rd_engine #(
    .TIMEOUT (TIMEOUT)
  ) u_rd_engine (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .rd_addr (rd_addr),
    .bus     (bus),
    .issued  (issued),
    .done    (done),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      gap_cnt    <= 8'h00;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      // done only occurs in the wait states; an error beats a clear.
      if (done && rd_err) begin
        err_flag <= 1'b1;
      end else if (clr_err) begin
        err_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_STAT_REQ;
            busy  <= 1'b1;
          end
        end

        ST_STAT_REQ: begin
          if (issued) state <= ST_STAT_WAIT;
        end

        ST_STAT_WAIT: begin
          if (done) begin
            if (rd_err || !rd_data[STAT_RXV_BIT]) begin
              state   <= ST_GAP;
              gap_cnt <= 8'h00;
            end else begin
              state <= ST_DATA_REQ;
            end
          end
        end

        ST_DATA_REQ: begin
          if (issued) state <= ST_DATA_WAIT;
        end

        ST_DATA_WAIT: begin
          if (done) begin
            if (rd_err) begin
              state   <= ST_GAP;
              gap_cnt <= 8'h00;
            end else begin
              byte_data  <= rd_data[7:0];
              byte_valid <= 1'b1;
              state      <= ST_HOLD;
            end
          end
        end

        // A delivered byte drains straight into the next status poll so a
        // burst in the UART FIFO is emptied without gap delays.
        ST_HOLD: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            if (enable) begin
              state <= ST_STAT_REQ;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (enable) begin
              state <= ST_STAT_REQ;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_poller
// Description : Self-checking bench for uart_rx_poller. A behavioural UART
//               register device answers bus reads from a byte FIFO; every
//               successful data read is expected to emerge once, in order,
//               on the byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_poller;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [31:0] STAT = BASE + 32'h8;
  localparam logic [31:0] DATA = BASE;
  localparam int          GAP  = 4;
  localparam int          TMO  = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       byte_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       busy;
  logic       err_flag;

  uart_rx_poller_if bus ();

  uart_rx_poller #(
    .BASE_ADDR (BASE),
    .POLL_GAP  (GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .bus        (bus),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .err_flag   (err_flag),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Device model state and knobs
  logic [7:0]  fifo[$];
  logic [7:0]  exp_q[$];
  int          grant_cyc[$];
  logic [31:0] grant_addr[$];
  int          hs_cyc[$];
  int          delivered = 0;
  int          data_rv_cyc = -1;
  int          gnt_delay = 0;
  int          rv_delay = 1;
  bit          err_data_once = 0;
  bit          pending = 0;
  bit          expect_data = 0;
  int          gwait = 0;
  int          rvcnt = 0;
  logic [31:0] paddr = 32'h0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART register device: decides gnt/rvalid for the coming edge.
  initial begin
    logic [7:0] b;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.err = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0; bus.rdata = $urandom;
      if (!resetn) begin
        pending = 0; gwait = 0; expect_data = 0;
      end else if (pending) begin
        rvcnt--;
        if (rvcnt == 0) begin
          pending = 0;
          bus.rvalid = 1'b1;
          if (paddr == STAT) begin
            bus.rdata[0] = (fifo.size() != 0);
            expect_data = bus.rdata[0];
          end else begin
            data_rv_cyc = cyc;
            if (err_data_once) begin
              bus.err = 1'b1;
              err_data_once = 0;
              if (fifo.size() != 0) void'(fifo.pop_front());
            end else begin
              if (fifo.size() != 0) b = fifo.pop_front();
              else b = 8'($urandom);
              bus.rdata[7:0] = b;
              exp_q.push_back(b);
            end
          end
        end
      end else if (bus.req) begin
        checks++;
        if (bus.be !== 4'b0001 || bus.we !== 1'b0 || bus.wdata !== 32'h0) begin
          errors++;
          $display("FAIL bus_attrs: be=%b we=%b wdata=%h, required be=0001 we=0 wdata=0",
                   bus.be, bus.we, bus.wdata);
        end
        checks++;
        if (!(bus.addr == STAT || (bus.addr == DATA && expect_data))) begin
          errors++;
          $display("FAIL read_addr: addr=%h expect_data=%0d, required status addr %h or data addr %h after RX-valid status",
                   bus.addr, expect_data, STAT, DATA);
        end
        if (gwait >= gnt_delay) begin
          bus.gnt = 1'b1;
          pending = 1; gwait = 0; rvcnt = rv_delay; paddr = bus.addr;
          grant_cyc.push_back(cyc);
          grant_addr.push_back(bus.addr);
          if (bus.addr == DATA) expect_data = 0;
        end else begin
          gwait++;
        end
      end
    end
  end

  // Consumer-side scoreboard: bytes must appear in the order they were read.
  initial forever begin
    @(negedge clk);
    #3;
    if (resetn && byte_valid && byte_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_stream: got byte %h, required no byte", byte_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_data !== e) begin
          errors++;
          $display("FAIL byte_stream: got %h, required %h", byte_data, e);
        end
      end
      hs_cyc.push_back(cyc);
      delivered++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_byte_valid(input int limit);
    for (int i = 0; i < limit && byte_valid !== 1'b1; i++) tick();
  endtask

  task automatic wait_new_grant(input int base_sz, input int limit);
    for (int i = 0; i < limit && grant_cyc.size() <= base_sz; i++) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.req !== 1'b0 || bus.addr !== 32'h0 || bus.be !== 4'h0 ||
        bus.we !== 1'b0 || bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: req=%b addr=%h be=%b we=%b wdata=%h, required all zero",
               bus.req, bus.addr, bus.be, bus.we, bus.wdata);
    end
    checks++;
    if (byte_data !== 8'h00 || byte_valid !== 1'b0 || busy !== 1'b0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: byte_data=%h byte_valid=%b busy=%b err_flag=%b, required all zero",
               byte_data, byte_valid, busy, err_flag);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_idle_poll();
    int  idx;
    bit  saw_valid = 0;
    idx = grant_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 80 && grant_cyc.size() < idx + 5; i++) begin
      tick();
      if (byte_valid) saw_valid = 1;
    end
    checks++;
    if (grant_cyc.size() < idx + 5) begin
      errors++;
      $display("FAIL idle_poll_count: got %0d polls, required 5", grant_cyc.size() - idx);
    end else begin
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (grant_cyc[idx+k] - grant_cyc[idx+k-1] != 3 + GAP || grant_addr[idx+k] !== STAT) begin
          errors++;
          $display("FAIL idle_poll_period: period=%0d addr=%h, required period=%0d addr=%h",
                   grant_cyc[idx+k] - grant_cyc[idx+k-1], grant_addr[idx+k], 3 + GAP, STAT);
        end
      end
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL idle_no_byte: byte_valid=1, required 0");
    end
  endtask

  task automatic test_single_byte();
    int sz;
    byte_ready = 1'b0;
    fifo.push_back(8'h41);
    wait_byte_valid(100);
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h41 || cyc != data_rv_cyc + 1) begin
      errors++;
      $display("FAIL single_byte: valid=%b data=%h rise_delay=%0d, required valid=1 data=41 rise_delay=1",
               byte_valid, byte_data, cyc - data_rv_cyc);
    end
    repeat (3) tick();
    sz = grant_cyc.size();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_fall: byte_valid=%b, required 0", byte_valid);
    end
    wait_new_grant(sz, 30);
    checks++;
    if (grant_cyc.size() <= sz || hs_cyc.size() == 0 ||
        grant_cyc[$] - hs_cyc[$] != 2 || grant_addr[$] !== STAT) begin
      errors++;
      $display("FAIL drain_no_gap: grants=%0d required>%0d, final addr %h required %h, delay required 2",
               grant_cyc.size(), sz, grant_addr[$], STAT);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    int         sz;
    bit         bad = 0;
    b = 8'($urandom);
    byte_ready = 1'b0;
    fifo.push_back(b);
    wait_byte_valid(100);
    sz = grant_cyc.size();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (byte_valid !== 1'b1 || byte_data !== b || bus.req !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || grant_cyc.size() != sz) begin
      errors++;
      $display("FAIL backpressure: valid=%b data=%h req=%b new_grants=%0d, required valid=1 data=%h req=0 new_grants=0",
               byte_valid, byte_data, bus.req, grant_cyc.size() - sz, b);
    end
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    wait_new_grant(sz, 30);
    checks++;
    if (grant_cyc.size() <= sz || grant_addr[$] !== STAT) begin
      errors++;
      $display("FAIL backpressure_restart: grants=%0d addr=%h, required a status read at %h",
               grant_cyc.size() - sz, grant_addr[$], STAT);
    end
  endtask

  task automatic test_stalled_gnt();
    int          n = 0;
    int          sz;
    logic [31:0] a0;
    bit          moved = 0;
    gnt_delay = 5;
    for (int i = 0; i < 30 && bus.req === 1'b1; i++) tick();
    for (int i = 0; i < 30 && bus.req !== 1'b1; i++) tick();
    sz = grant_cyc.size();
    a0 = bus.addr;
    for (int i = 0; i < 30 && bus.req === 1'b1; i++) begin
      n++;
      if (bus.addr !== a0) moved = 1;
      tick();
    end
    gnt_delay = 0;
    checks++;
    if (n != 6 || moved || a0 !== STAT || grant_cyc.size() != sz + 1) begin
      errors++;
      $display("FAIL stalled_gnt: req_cycles=%0d addr=%h moved=%0d grants=%0d, required 6 %h 0 1",
               n, a0, moved, grant_cyc.size() - sz, STAT);
    end
  endtask

  task automatic test_errors();
    int  sz;
    bit  saw_valid = 0;
    // error on the data response
    err_data_once = 1;
    fifo.push_back(8'($urandom));
    for (int i = 0; i < 100 && err_flag !== 1'b1; i++) begin
      tick();
      if (byte_valid) saw_valid = 1;
    end
    repeat (10) begin
      tick();
      if (byte_valid) saw_valid = 1;
    end
    checks++;
    if (err_flag !== 1'b1 || saw_valid || exp_q.size() != 0) begin
      errors++;
      $display("FAIL data_err: err_flag=%b saw_byte=%0d, required err_flag=1 saw_byte=0", err_flag, saw_valid);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: err_flag=%b, required 0", err_flag);
    end

    // response withheld one cycle past the limit; late status says RX valid
    byte_ready = 1'b1;
    fifo.push_back(8'($urandom));
    rv_delay = TMO + 1;
    for (int i = 0; i < 200 && err_flag !== 1'b1; i++) tick();
    rv_delay = 1;
    sz = grant_cyc.size();
    checks++;
    if (err_flag !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout: err_flag=%b busy=%b, required 1 1", err_flag, busy);
    end
    wait_new_grant(sz, 30);
    checks++;
    if (grant_cyc.size() <= sz || grant_addr[sz] !== STAT) begin
      errors++;
      $display("FAIL late_rvalid: next read addr=%h, required %h", grant_addr[$], STAT);
    end
    for (int i = 0; i < 100 && (fifo.size() != 0 || exp_q.size() != 0); i++) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // response on the last permitted wait cycle is still accepted
    rv_delay = TMO;
    sz = grant_cyc.size();
    for (int i = 0; i < 120 && grant_cyc.size() < sz + 3; i++) tick();
    rv_delay = 1;
    checks++;
    if (err_flag !== 1'b0 || grant_cyc.size() < sz + 3) begin
      errors++;
      $display("FAIL timeout_edge: err_flag=%b polls=%0d, required err_flag=0 polls>=3",
               err_flag, grant_cyc.size() - sz);
    end

    // error and clear in the same cycle: error wins
    clr_err = 1'b1;
    rv_delay = TMO + 1;
    for (int i = 0; i < 200 && err_flag !== 1'b1; i++) tick();
    rv_delay = 1;
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_beats_clr: err_flag=%b, required 1", err_flag);
    end
    tick();
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_err: err_flag=%b, required 0", err_flag);
    end
    clr_err = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    int pushed = 0;
    start_cnt = delivered;
    for (int i = 0; i < 3000 && (pushed < 12 || fifo.size() != 0 || exp_q.size() != 0 || byte_valid); i++) begin
      if (pushed < 12 && $urandom_range(0, 3) == 0) begin
        fifo.push_back(8'($urandom));
        pushed++;
      end
      gnt_delay  = $urandom_range(0, 3);
      rv_delay   = $urandom_range(1, 4);
      byte_ready = 1'($urandom_range(0, 1));
      tick();
    end
    gnt_delay = 0;
    rv_delay = 1;
    byte_ready = 1'b0;
    checks++;
    if (delivered - start_cnt != 12 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL random_stream: delivered=%0d err_flag=%b, required 12 and 0",
               delivered - start_cnt, err_flag);
    end
  endtask

  task automatic test_enable_off();
    int sz;
    // disable while a byte is held: byte still delivered, then idle
    fifo.push_back(8'($urandom));
    wait_byte_valid(100);
    enable = 1'b0;
    repeat (3) tick();
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    tick();
    sz = grant_cyc.size();
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || grant_cyc.size() != sz || exp_q.size() != 0) begin
      errors++;
      $display("FAIL enable_off_hold: busy=%b new_reads=%0d, required 0 0", busy, grant_cyc.size() - sz);
    end
    // disable during GAP
    enable = 1'b1;
    sz = grant_cyc.size();
    wait_new_grant(sz, 30);
    repeat (2) tick();
    enable = 1'b0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
    sz = grant_cyc.size();
    repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || bus.req !== 1'b0 || grant_cyc.size() != sz) begin
      errors++;
      $display("FAIL enable_off_gap: busy=%b req=%b new_reads=%0d, required 0 0 0",
               busy, bus.req, grant_cyc.size() - sz);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    rv_delay = 10;
    fifo.push_back(8'($urandom));
    for (int i = 0; i < 100 && !(grant_addr.size() != 0 && grant_addr[$] == DATA); i++) tick();
    repeat (2) tick();
    resetn = 1'b0;
    enable = 1'b0;
    tick();
    checks++;
    if (bus.req !== 1'b0 || bus.addr !== 32'h0 || bus.be !== 4'h0 || busy !== 1'b0 ||
        byte_valid !== 1'b0 || byte_data !== 8'h00 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b addr=%h be=%b busy=%b valid=%b data=%h err=%b, required all zero",
               bus.req, bus.addr, bus.be, busy, byte_valid, byte_data, err_flag);
    end
    rv_delay = 1;
    fifo.delete();
    exp_q.delete();
    resetn = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || bus.req !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: busy=%b req=%b, required 0 0", busy, bus.req);
    end
  endtask

  initial begin
    test_reset();
    test_idle_poll();
    test_single_byte();
    test_backpressure();
    test_stalled_gnt();
    test_errors();
    test_back_to_back();
    test_enable_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
